odelay_load_sequencer: RTL and testbench
========================================

# odelay_load_sequencer

Sequences delay-tap updates for a bank of fine-pipelined output delay lanes sharing one 8-bit delay bus. Host commands stage per-lane values with one-hot `ld` strobes, then commit all staged values at once with a single `set` strobe, followed by a settle interval. The block keeps shadow copies of staged and applied values per lane for readback. It sits between the memory-controller command/config path and the per-lane odelay wrappers.

## Interface
- `NUM_LANES`, 10: number of delay lanes driven; range 1..16.
- `ADDR_WIDTH`, 4: lane address width; must satisfy 2^ADDR_WIDTH >= NUM_LANES.
- `SETTLE_CYCLES`, 4: idle cycles after `dly_set` before `done`; range 0..255.
- `DELAY_VALUE`, 8'h00: reset value of every shadow register; must match the lanes' reset delay.

- `clk` in 1: single clock for all logic and the lanes.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block accepts a command; high only in IDLE.
- `cmd_set` in 1: 0 = LOAD command (stage `cmd_data` into lane `cmd_addr`); 1 = SET command (commit all staged values).
- `cmd_addr` in ADDR_WIDTH: target lane for LOAD; ignored for SET.
- `cmd_data` in 8: delay value for LOAD; [7:3] coarse, [2:0] fine.
- `dly_data` out 8: shared delay bus to all lanes.
- `dly_ld` out NUM_LANES: one-hot per-lane load strobe.
- `dly_set` out 1: common commit strobe to all lanes.
- `done` out 1: one-cycle pulse when a command completes.
- `err` out 1: sticky; set by a LOAD to an address >= NUM_LANES; cleared only by `rst`.
- `dirty` out 1: at least one LOAD accepted since the last commit.
- `rd_addr` in ADDR_WIDTH: readback lane select.
- `rd_staged` out 8: staged value of `rd_addr`, registered.
- `rd_applied` out 8: applied value of `rd_addr`, registered.

## Operation
- FSM states: IDLE, LOAD, SET, SETTLE.
- IDLE:
  - Accept a command when `cmd_valid & cmd_ready`.
  - LOAD with a valid address goes to LOAD. It latches `dly_data <= cmd_data`, `dly_ld <= 1<<cmd_addr`, `staged[addr] <= cmd_data`, and sets `dirty`.
  - LOAD with an invalid address stays in IDLE. It sets `err`, pulses `done` the next cycle, and changes no other state.
  - SET with `dirty=1` goes to SET and registers `dly_set <= 1`.
  - SET with `dirty=0` stays in IDLE, pulses `done` the next cycle, and emits no `dly_set`.
- LOAD (1 cycle):
  - `dly_ld` is high for exactly this cycle; `done` pulses.
  - Next state is IDLE.
- SET (1 cycle):
  - `dly_set` is high.
  - `applied[i] <= staged[i]` for all lanes; `dirty` clears.
  - If SETTLE_CYCLES = 0: next state is IDLE and `done` pulses this cycle.
  - Otherwise: next state is SETTLE and the counter loads SETTLE_CYCLES-1.
- SETTLE:
  - Counter decrements each cycle.
  - At 0: `done` pulses and next state is IDLE.
- `dly_data` holds its last value between loads.
  - A lane samples it only while its `dly_ld` is high.
- Readback: `rd_staged`/`rd_applied` update every cycle from `rd_addr`. An out-of-range `rd_addr` returns 8'h00.
- Reset:
  - Forces IDLE.
  - Outputs: `dly_ld`=0, `dly_set`=0, `done`=0, `err`=0, `dirty`=0, `dly_data`=DELAY_VALUE.
  - All staged and applied shadows = DELAY_VALUE.
  - A reset asserted mid-LOAD/SET/SETTLE aborts the command: no `done`, and no strobe in the cycle after reset.
  - Reset has priority over an accepted command in the same cycle.

## Timing
- LOAD accepted at edge N:
  - `dly_ld`/`dly_data` valid in cycle N+1; `done` in N+1.
  - `cmd_ready` high again in N+2.
  - Throughput: one LOAD per 2 cycles.
- SET accepted at edge N:
  - `dly_set` in N+1.
  - `done` in N+1+SETTLE_CYCLES.
  - `cmd_ready` high again at N+2+SETTLE_CYCLES.
- `rd_*` latency: 1 cycle from `rd_addr`.
  - A readback in the same cycle as a shadow write returns the old value.
- At most one of `dly_ld` (any bit) or `dly_set` is high in any cycle.

## Structure
- Shared package `odelay_seq_pkg`: state enum (IDLE, LOAD, SET, SETTLE), the 8-bit delay width constant, and the coarse/fine split constants (5/3).
- Sub-module `odelay_shadow_regs`:
  - Holds the NUM_LANES × 8 staged and applied arrays.
  - Provides a write port, a bulk-copy strobe, and a registered readback.
- The FSM and settle counter live in the top level.

## Test plan
- Reset, then LOAD addr 3 = 8'h2D:
  - `dly_ld` = 10'b0000001000 for 1 cycle with `dly_data` = 8'h2D.
  - `done` pulses; `dirty`=1; `rd_staged`(3) = 8'h2D; `rd_applied`(3) = DELAY_VALUE.
- LOAD lanes 0 and 9, then SET with SETTLE_CYCLES=4:
  - `dly_set` pulses once; `done` arrives 4 cycles later.
  - `cmd_ready` stays low through SETTLE.
  - `rd_applied` matches the staged values; `dirty`=0.
- SET with `dirty`=0: no `dly_set`; `done` pulses the cycle after acceptance.
- LOAD addr 12 (NUM_LANES=10): `err`=1 and stays sticky, no `dly_ld`, shadows unchanged, `done` pulses.
- Assert `rst` during SETTLE:
  - No `done` and no strobes.
  - All shadows = DELAY_VALUE; `cmd_ready`=1 the cycle after reset deasserts.
- Back-to-back `cmd_valid` held high with 5 LOADs: each `dly_ld` pulse is separated by exactly one idle cycle, and no two strobes overlap.

Source files
------------

// File: rtl/odelay_seq_pkg.sv
// -----------------------------------------------------------------------------
// odelay_seq_pkg
// Shared definitions for the odelay load sequencer:
//   - state_e    : sequencer FSM states (IDLE, LOAD, SET, SETTLE)
//   - DLY_W      : width of one delay-tap value on the shared bus
//   - COARSE_W / FINE_W : split of a delay value into coarse [7:3] and fine [2:0]
//   - dly_coarse / dly_fine : field extraction helpers for that split
// -----------------------------------------------------------------------------
package odelay_seq_pkg;

  localparam int DLY_W    = 8;
  localparam int COARSE_W = 5;
  localparam int FINE_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SET    = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  function automatic logic [COARSE_W-1:0] dly_coarse(input logic [DLY_W-1:0] d);
    return d[DLY_W-1:FINE_W];
  endfunction

  function automatic logic [FINE_W-1:0] dly_fine(input logic [DLY_W-1:0] d);
    return d[FINE_W-1:0];
  endfunction

endpackage

// File: rtl/odelay_shadow_regs.sv
// -----------------------------------------------------------------------------
// odelay_shadow_regs
// Per-lane shadow copies of the delay values: "staged" holds the value most
// recently loaded into a lane, "applied" holds the value the lane is actually
// using after the last commit.
//
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset (all shadows and
//                       readback registers go to DELAY_VALUE)
//   wr_en_i           : write wr_data_i into staged[wr_addr_i]
//   wr_addr_i         : lane index for the write (out-of-range writes ignored)
//   wr_data_i         : delay value to stage
//   commit_i          : copy every staged value into applied in one cycle
//   rd_addr_i         : readback lane select
//   rd_staged_o       : registered staged[rd_addr_i], 8'h00 if out of range
//   rd_applied_o      : registered applied[rd_addr_i], 8'h00 if out of range
// -----------------------------------------------------------------------------
module odelay_shadow_regs
  import odelay_seq_pkg::*;
#(
  parameter int               NUM_LANES   = 10,
  parameter int               ADDR_WIDTH  = 4,
  parameter logic [DLY_W-1:0] DELAY_VALUE = 8'h00
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DLY_W-1:0]      wr_data_i,
  input  logic                  commit_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DLY_W-1:0]      rd_staged_o,
  output logic [DLY_W-1:0]      rd_applied_o
);

  logic [DLY_W-1:0] staged_q  [NUM_LANES];
  logic [DLY_W-1:0] applied_q [NUM_LANES];
  logic [DLY_W-1:0] rd_staged_q, rd_staged_d;
  logic [DLY_W-1:0] rd_applied_q, rd_applied_d;

  // Readback mux: any address without a matching lane falls through to zero.
  always_comb begin
    rd_staged_d  = '0;
    rd_applied_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (rd_addr_i == ADDR_WIDTH'(i)) begin
        rd_staged_d  = staged_q[i];
        rd_applied_d = applied_q[i];
      end
    end
  end

  // The commit copies the pre-edge staged contents, so a write and a commit in
  // the same cycle would commit the old value. The sequencer never issues both.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        staged_q[i]  <= DELAY_VALUE;
        applied_q[i] <= DELAY_VALUE;
      end
      rd_staged_q  <= DELAY_VALUE;
      rd_applied_q <= DELAY_VALUE;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_en_i && (wr_addr_i == ADDR_WIDTH'(i))) begin
          staged_q[i] <= wr_data_i;
        end
        if (commit_i) begin
          applied_q[i] <= staged_q[i];
        end
      end
      rd_staged_q  <= rd_staged_d;
      rd_applied_q <= rd_applied_d;
    end
  end

  assign rd_staged_o  = rd_staged_q;
  assign rd_applied_o = rd_applied_q;

endmodule

// File: rtl/odelay_load_sequencer.sv
// -----------------------------------------------------------------------------
// odelay_load_sequencer
// Sequences delay-tap updates for a bank of output delay lanes sharing one
// 8-bit delay bus. LOAD commands stage a value into one lane (one-hot dly_ld
// strobe); a SET command commits all staged values with one dly_set strobe,
// followed by SETTLE_CYCLES idle cycles before done.
//
// Command handshake: a command transfers on a rising edge where
// cmd_valid_i && cmd_ready_o. cmd_ready_o is high only in IDLE; the command
// fields must be stable while cmd_valid_i is high and not yet accepted.
//
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset (aborts any command)
//   cmd_valid_i    : command present
//   cmd_ready_o    : command accepted this edge if valid (IDLE only)
//   cmd_set_i      : 0 = LOAD cmd_data_i into lane cmd_addr_i, 1 = SET (commit)
//   cmd_addr_i     : target lane for LOAD
//   cmd_data_i     : delay value for LOAD ([7:3] coarse, [2:0] fine)
//   dly_data_o     : shared delay bus, holds its value between loads
//   dly_ld_o       : one-hot per-lane load strobe
//   dly_set_o      : common commit strobe
//   done_o         : one-cycle pulse when a command completes
//   err_o          : sticky, set by a LOAD to an address >= NUM_LANES
//   dirty_o        : a LOAD was accepted since the last commit
//   rd_addr_i      : readback lane select
//   rd_staged_o    : registered staged value of rd_addr_i
//   rd_applied_o   : registered applied value of rd_addr_i
//   state_o        : current FSM state (debug)
// -----------------------------------------------------------------------------
module odelay_load_sequencer
  import odelay_seq_pkg::*;
#(
  parameter int               NUM_LANES     = 10,
  parameter int               ADDR_WIDTH    = 4,
  parameter int               SETTLE_CYCLES = 4,
  parameter logic [DLY_W-1:0] DELAY_VALUE   = 8'h00
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_set_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DLY_W-1:0]      cmd_data_i,
  output logic [DLY_W-1:0]      dly_data_o,
  output logic [NUM_LANES-1:0]  dly_ld_o,
  output logic                  dly_set_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  dirty_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DLY_W-1:0]      rd_staged_o,
  output logic [DLY_W-1:0]      rd_applied_o,
  output state_e                state_o
);

  // Counter reload value on entering SETTLE; done is pre-registered one
  // cycle early so it is high in the cycle the counter reads zero.
  localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
  localparam logic       SETTLE_ZERO = (SETTLE_CYCLES == 0);
  localparam logic       SETTLE_ONE  = (SETTLE_CYCLES == 1);
  localparam logic [ADDR_WIDTH:0] LANES_W = (ADDR_WIDTH + 1)'(NUM_LANES);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DLY_W-1:0]      dly_data_q, dly_data_d;
  logic [NUM_LANES-1:0]  dly_ld_q, dly_ld_d;
  logic                  dly_set_q, dly_set_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  dirty_q, dirty_d;

  logic                  cmd_fire;
  logic                  addr_ok;
  logic [NUM_LANES-1:0]  lane_sel;
  logic                  shadow_wr;
  logic                  shadow_commit;

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign addr_ok     = ({1'b0, cmd_addr_i} < LANES_W);

  always_comb begin
    lane_sel = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_sel[i] = (cmd_addr_i == ADDR_WIDTH'(i));
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dly_data_d = dly_data_q;
    dly_ld_d   = '0;
    dly_set_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    dirty_d    = dirty_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (!cmd_set_i) begin
            if (addr_ok) begin
              state_d    = ST_LOAD;
              dly_data_d = cmd_data_i;
              dly_ld_d   = lane_sel;
              dirty_d    = 1'b1;
              done_d     = 1'b1;
            end else begin
              // Bad lane: flag it and complete without touching anything else.
              err_d  = 1'b1;
              done_d = 1'b1;
            end
          end else if (dirty_q) begin
            state_d   = ST_SET;
            dly_set_d = 1'b1;
            done_d    = SETTLE_ZERO;
          end else begin
            // Nothing staged: complete immediately with no commit strobe.
            done_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
      end
      ST_SET: begin
        dirty_d = 1'b0;
        if (SETTLE_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
          done_d  = SETTLE_ONE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d  = cnt_q - 8'd1;
          done_d = (cnt_q == 8'd1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      dly_data_q <= DELAY_VALUE;
      dly_ld_q   <= '0;
      dly_set_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      dirty_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dly_data_q <= dly_data_d;
      dly_ld_q   <= dly_ld_d;
      dly_set_q  <= dly_set_d;
      done_q     <= done_d;
      err_q      <= err_d;
      dirty_q    <= dirty_d;
    end
  end

  assign shadow_wr     = cmd_fire && !cmd_set_i && addr_ok;
  assign shadow_commit = (state_q == ST_SET);

  odelay_shadow_regs #(
    .NUM_LANES   (NUM_LANES),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DELAY_VALUE (DELAY_VALUE)
  ) u_shadow (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr_en_i      (shadow_wr),
    .wr_addr_i    (cmd_addr_i),
    .wr_data_i    (cmd_data_i),
    .commit_i     (shadow_commit),
    .rd_addr_i    (rd_addr_i),
    .rd_staged_o  (rd_staged_o),
    .rd_applied_o (rd_applied_o)
  );

  assign dly_data_o = dly_data_q;
  assign dly_ld_o   = dly_ld_q;
  assign dly_set_o  = dly_set_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign dirty_o    = dirty_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_odelay_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_odelay_load_sequencer
// Directed bench for odelay_load_sequencer (10 lanes, 4 settle cycles,
// shadow reset value 8'h11). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, i.e. they show the registers loaded
// by the edge just passed.
// -----------------------------------------------------------------------------
module tb_odelay_load_sequencer;
  import odelay_seq_pkg::*;

  localparam int         NL = 10;
  localparam int         AW = 4;
  localparam int         SC = 4;
  localparam logic [7:0] DV = 8'h11;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_set = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_data = '0;
  logic [7:0]    dly_data;
  logic [NL-1:0] dly_ld;
  logic          dly_set;
  logic          done;
  logic          err;
  logic          dirty;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_staged;
  logic [7:0]    rd_applied;
  state_e        state;

  int checks = 0;
  int errors = 0;
  logic [NL-1:0] exp_q[$];

  odelay_load_sequencer #(
    .NUM_LANES(NL), .ADDR_WIDTH(AW), .SETTLE_CYCLES(SC), .DELAY_VALUE(DV)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_set_i(cmd_set),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .dly_data_o(dly_data), .dly_ld_o(dly_ld), .dly_set_o(dly_set),
    .done_o(done), .err_o(err), .dirty_o(dirty),
    .rd_addr_i(rd_addr), .rd_staged_o(rd_staged), .rd_applied_o(rd_applied),
    .state_o(state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for exactly one edge (caller ensures cmd_ready is high).
  task automatic drive_cmd(input logic set, input logic [AW-1:0] addr, input logic [7:0] data);
    cmd_valid = 1'b1; cmd_set = set; cmd_addr = addr; cmd_data = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; rd_addr = 4'd0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    checks++; if (dly_ld !== 10'b0) begin errors++; $display("FAIL reset_ld got %b want 0", dly_ld); end
    checks++; if (dly_set !== 1'b0) begin errors++; $display("FAIL reset_set got %b want 0", dly_set); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL reset_dirty got %b want 0", dirty); end
    checks++; if (dly_data !== 8'h11) begin errors++; $display("FAIL reset_data got %h want 11", dly_data); end
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    tick();
    checks++; if (rd_staged !== 8'h11) begin errors++; $display("FAIL reset_rd_staged got %h want 11", rd_staged); end
    checks++; if (rd_applied !== 8'h11) begin errors++; $display("FAIL reset_rd_applied got %h want 11", rd_applied); end
  endtask

  task automatic test_load();
    rd_addr = 4'd3;
    drive_cmd(1'b0, 4'd3, 8'h2D);
    checks++; if (dly_ld !== 10'b0000001000) begin errors++; $display("FAIL load_ld got %b want 0000001000", dly_ld); end
    checks++; if (dly_data !== 8'h2D) begin errors++; $display("FAIL load_data got %h want 2d", dly_data); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL load_done got %b want 1", done); end
    checks++; if (dirty !== 1'b1) begin errors++; $display("FAIL load_dirty got %b want 1", dirty); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL load_ready got %b want 0", cmd_ready); end
    checks++; if (dly_set !== 1'b0) begin errors++; $display("FAIL load_noset got %b want 0", dly_set); end
    tick();
    checks++; if (dly_ld !== 10'b0) begin errors++; $display("FAIL load_ld_end got %b want 0", dly_ld); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_done_end got %b want 0", done); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL load_ready_back got %b want 1", cmd_ready); end
    checks++; if (dly_data !== 8'h2D) begin errors++; $display("FAIL load_data_hold got %h want 2d", dly_data); end
    checks++; if (rd_staged !== 8'h2D) begin errors++; $display("FAIL load_rd_staged got %h want 2d", rd_staged); end
    checks++; if (rd_applied !== 8'h11) begin errors++; $display("FAIL load_rd_applied got %h want 11", rd_applied); end
  endtask

  task automatic test_set_settle();
    int sets;
    drive_cmd(1'b0, 4'd0, 8'h05);
    tick();
    drive_cmd(1'b0, 4'd9, 8'hF3);
    checks++; if (dly_ld !== 10'b1000000000) begin errors++; $display("FAIL set_ld9 got %b want 1000000000", dly_ld); end
    tick();
    drive_cmd(1'b1, 4'd0, 8'h00);
    sets = 0;
    if (dly_set === 1'b1) sets++;
    checks++; if (dly_set !== 1'b1) begin errors++; $display("FAIL set_strobe got %b want 1", dly_set); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL set_done_early got %b want 0", done); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL set_ready got %b want 0", cmd_ready); end
    checks++; if (dirty !== 1'b1) begin errors++; $display("FAIL set_dirty_pre got %b want 1", dirty); end
    // cycles N+2 .. N+6 after acceptance
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (dly_set === 1'b1) sets++;
      checks++; if (done !== (c == 5)) begin errors++; $display("FAIL settle_done c=%0d got %b want %b", c, done, (c == 5)); end
      checks++; if (cmd_ready !== (c == 6)) begin errors++; $display("FAIL settle_ready c=%0d got %b want %b", c, cmd_ready, (c == 6)); end
      checks++; if (dly_ld !== 10'b0) begin errors++; $display("FAIL settle_ld c=%0d got %b want 0", c, dly_ld); end
      if (c == 2) begin
        checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL set_dirty_clr got %b want 0", dirty); end
        checks++; if (state !== ST_SETTLE) begin errors++; $display("FAIL settle_state got %0d want 3", state); end
      end
    end
    checks++; if (sets !== 1) begin errors++; $display("FAIL set_count got %0d want 1", sets); end
    rd_addr = 4'd0; tick();
    checks++; if (rd_applied !== 8'h05) begin errors++; $display("FAIL applied0 got %h want 05", rd_applied); end
    checks++; if (rd_staged !== 8'h05) begin errors++; $display("FAIL staged0 got %h want 05", rd_staged); end
    rd_addr = 4'd9; tick();
    checks++; if (rd_applied !== 8'hF3) begin errors++; $display("FAIL applied9 got %h want f3", rd_applied); end
    rd_addr = 4'd3; tick();
    checks++; if (rd_applied !== 8'h2D) begin errors++; $display("FAIL applied3 got %h want 2d", rd_applied); end
  endtask

  task automatic test_set_clean();
    drive_cmd(1'b1, 4'd0, 8'h00);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL clean_done got %b want 1", done); end
    checks++; if (dly_set !== 1'b0) begin errors++; $display("FAIL clean_noset got %b want 0", dly_set); end
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL clean_state got %0d want 0", state); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clean_done_end got %b want 0", done); end
    checks++; if (dly_set !== 1'b0) begin errors++; $display("FAIL clean_noset2 got %b want 0", dly_set); end
  endtask

  task automatic test_err();
    rd_addr = 4'd3;
    drive_cmd(1'b0, 4'd12, 8'hAA);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL err_done got %b want 1", done); end
    checks++; if (dly_ld !== 10'b0) begin errors++; $display("FAIL err_ld got %b want 0", dly_ld); end
    checks++; if (dly_data !== 8'hF3) begin errors++; $display("FAIL err_data got %h want f3", dly_data); end
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL err_dirty got %b want 0", dirty); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL err_ready got %b want 1", cmd_ready); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL err_done_end got %b want 0", done); end
    checks++; if (rd_staged !== 8'h2D) begin errors++; $display("FAIL err_shadow got %h want 2d", rd_staged); end
    rd_addr = 4'd12; tick();
    checks++; if (rd_staged !== 8'h00) begin errors++; $display("FAIL rd_oor_staged got %h want 00", rd_staged); end
    checks++; if (rd_applied !== 8'h00) begin errors++; $display("FAIL rd_oor_applied got %h want 00", rd_applied); end
    drive_cmd(1'b0, 4'd2, 8'h44);
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky2 got %b want 1", err); end
  endtask

  task automatic test_reset_settle();
    int strobes;
    rd_addr = 4'd5;
    drive_cmd(1'b0, 4'd5, 8'h7C);
    tick();
    drive_cmd(1'b1, 4'd0, 8'h00);
    tick();
    checks++; if (state !== ST_SETTLE) begin errors++; $display("FAIL rs_state got %0d want 3", state); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rs_done got %b want 0", done); end
    checks++; if (dly_set !== 1'b0) begin errors++; $display("FAIL rs_set got %b want 0", dly_set); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rs_err got %b want 0", err); end
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL rs_dirty got %b want 0", dirty); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rs_ready got %b want 1", cmd_ready); end
    checks++; if (dly_data !== 8'h11) begin errors++; $display("FAIL rs_data got %h want 11", dly_data); end
    strobes = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if ((done === 1'b1) || (dly_set === 1'b1) || (dly_ld !== 10'b0)) strobes++;
    end
    checks++; if (strobes !== 0) begin errors++; $display("FAIL rs_quiet got %0d want 0", strobes); end
    checks++; if (rd_staged !== 8'h11) begin errors++; $display("FAIL rs_staged5 got %h want 11", rd_staged); end
    checks++; if (rd_applied !== 8'h11) begin errors++; $display("FAIL rs_applied5 got %h want 11", rd_applied); end
    rd_addr = 4'd0; tick();
    checks++; if (rd_applied !== 8'h11) begin errors++; $display("FAIL rs_applied0 got %h want 11", rd_applied); end
    rd_addr = 4'd2; tick();
    checks++; if (rd_staged !== 8'h11) begin errors++; $display("FAIL rs_staged2 got %h want 11", rd_staged); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [5];
    logic [7:0]    datas [5];
    logic [NL-1:0] ones  [5];
    logic [NL-1:0] prev_ld;
    logic [NL-1:0] exp_ld;
    int k, pulses;
    addrs = '{4'd1, 4'd2, 4'd4, 4'd7, 4'd8};
    datas = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
    ones  = '{10'h002, 10'h004, 10'h010, 10'h080, 10'h100};
    for (int i = 0; i < 5; i++) exp_q.push_back(ones[i]);
    k = 0; pulses = 0; prev_ld = '0;
    cmd_valid = 1'b1; cmd_set = 1'b0; cmd_addr = addrs[0]; cmd_data = datas[0];
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      checks++; if ((dly_ld !== 10'b0) && (dly_set !== 1'b0)) begin errors++; $display("FAIL b2b_overlap cyc=%0d ld=%b set=%b", cyc, dly_ld, dly_set); end
      if (dly_ld !== 10'b0) begin
        exp_ld = (exp_q.size() > 0) ? exp_q.pop_front() : 10'b0;
        checks++; if (dly_ld !== exp_ld) begin errors++; $display("FAIL b2b_ld cyc=%0d got %b want %b", cyc, dly_ld, exp_ld); end
        checks++; if (cyc !== 2 * pulses) begin errors++; $display("FAIL b2b_spacing got cyc %0d want %0d", cyc, 2 * pulses); end
        checks++; if (prev_ld !== 10'b0) begin errors++; $display("FAIL b2b_gap cyc=%0d prev %b want 0", cyc, prev_ld); end
        checks++; if (dly_data !== datas[k]) begin errors++; $display("FAIL b2b_data cyc=%0d got %h want %h", cyc, dly_data, datas[k]); end
        pulses++;
        k++;
        if (k < 5) begin
          cmd_addr = addrs[k]; cmd_data = datas[k];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      prev_ld = dly_ld;
    end
    cmd_valid = 1'b0;
    checks++; if (pulses !== 5) begin errors++; $display("FAIL b2b_pulses got %0d want 5", pulses); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_leftover got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_set_settle();
    test_set_clean();
    test_err();
    test_reset_settle();
    test_back_to_back();
    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
